// File: rtl/i2c_adc_target.sv
// I2C target emulating the AD7991 ADC read protocol and config-byte write.
// Serves a single 12-bit hold register to the master as two bytes per sample.
module i2c_adc_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h28,
    parameter logic [7:0] CFG_RESET = 8'h10,
    parameter int         SYNC_LEN  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [7:0]  cfg_reg,
    output logic        cfg_wr,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_HI,
        S_RD_LO,
        S_M_ACK,
        S_IGNORE,
        S_WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_LEN-1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [7:0]  sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        full_q, full_d;
    logic        rw_q, rw_d;
    logic        lo_q, lo_d;
    logic        mack_q, mack_d;
    logic [11:0] tx_q, tx_d;
    logic [11:0] hold_q, hold_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  cfg_q, cfg_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic        snap;

    // Bus idles high, so the synchronizers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_LEN-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_LEN-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_LEN-1];
    assign sda_s     = sda_sync_q[SYNC_LEN-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= 8'h00;
            cnt_q    <= 3'd0;
            full_q   <= 1'b0;
            rw_q     <= 1'b0;
            lo_q     <= 1'b0;
            mack_q   <= 1'b0;
            tx_q     <= 12'h000;
            hold_q   <= 12'h000;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            cfg_q    <= CFG_RESET;
            cfg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            rw_q     <= rw_d;
            lo_q     <= lo_d;
            mack_q   <= mack_d;
            tx_q     <= tx_d;
            hold_q   <= hold_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            cfg_q    <= cfg_d;
            cfg_wr_q <= cfg_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        rw_d     = rw_q;
        lo_d     = lo_q;
        mack_d   = mack_q;
        tx_d     = tx_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        cfg_d    = cfg_q;
        cfg_wr_d = 1'b0;
        snap     = 1'b0;

        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_WR_BYTE: begin
                    if (scl_rise) begin
                        sh_d   = {sh_q[6:0], sda_s};
                        cnt_d  = cnt_q + 3'd1;
                        full_d = (cnt_q == 3'd7);
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        if (state_q == S_WR_BYTE) begin
                            state_d = S_WR_ACK;
                            oe_d    = 1'b1;
                        end else if (sh_q[7:1] == DEV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = sh_q[0];
                            snap    = sh_q[0];
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = S_RD_HI;
                            sh_d    = {4'b0000, tx_q[11:8]};
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_WR_BYTE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_WR_BYTE;
                        cfg_d    = sh_q;
                        cfg_wr_d = 1'b1;
                        cnt_d    = 3'd0;
                        oe_d     = 1'b0;
                    end
                end
                S_RD_HI, S_RD_LO: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            state_d = S_M_ACK;
                            lo_d    = (state_q == S_RD_LO);
                            cnt_d   = 3'd0;
                            oe_d    = 1'b0;
                        end else begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            cnt_d = cnt_q + 3'd1;
                            oe_d  = ~sh_q[6];
                        end
                    end
                end
                S_M_ACK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (!mack_q) begin
                            state_d = S_WAIT_STOP;
                            oe_d    = 1'b0;
                        end else if (lo_q) begin
                            state_d = S_RD_HI;
                            snap    = 1'b1;
                            sh_d    = {4'b0000, hold_q[11:8]};
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_RD_LO;
                            sh_d    = tx_q[7:0];
                            oe_d    = ~tx_q[7];
                        end
                    end
                end
                default: ;
            endcase
        end

        if (snap) begin
            tx_d = hold_q;
        end
    end

    // A snapshot cycle stalls the producer so the old value is captured intact.
    always_comb begin
        hold_d = hold_q;
        if (sample_valid && sample_ready) begin
            hold_d = sample_data;
        end
    end

    assign sample_ready = ~(snap & ~rst);
    assign sda_oe       = oe_q & ~rst;
    assign cfg_reg      = cfg_q;
    assign cfg_wr       = cfg_wr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: bit-banged I2C master, queue scoreboard
// for master-observed bus responses and config-register writes.
module tb_i2c_adc_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  cfg_reg;
    logic        cfg_wr;
    logic        busy;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_adc_target dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl_m),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .cfg_reg      (cfg_reg),
        .cfg_wr       (cfg_wr),
        .busy         (busy)
    );

    localparam int Q = 10;
    localparam logic [31:0] T_ACK  = 32'h100;
    localparam logic [31:0] T_BYTE = 32'h200;

    int total = 0;
    int bad = 0;
    int oe_cnt = 0;
    logic [31:0] exp_bus[$];
    logic [31:0] obs_bus[$];
    logic [31:0] exp_cfg[$];
    logic [31:0] obs_cfg[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (cfg_wr) obs_cfg.push_back({24'h0, cfg_reg});
    end

    // Scoreboard: pair each observed response with the oldest expectation.
    initial begin
        logic [31:0] e;
        logic [31:0] o;
        forever begin
            @(negedge clk);
            while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
                e = exp_bus.pop_front();
                o = obs_bus.pop_front();
                chk((e[9:8] == 2'd1) ? "bus_ack" : "rd_byte", o, e);
            end
            while (exp_cfg.size() > 0 && obs_cfg.size() > 0) begin
                e = exp_cfg.pop_front();
                o = obs_cfg.pop_front();
                chk("cfg_wr_value", o, e);
            end
        end
    end

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw();
        qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_line; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_bus.push_back(T_ACK | {31'h0, ~exp_ack});
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(a);
        obs_bus.push_back(T_ACK | {31'h0, a});
    endtask

    task automatic recv_byte(input logic [7:0] exp_b, input logic mack);
        logic [7:0] r;
        logic       b;
        exp_bus.push_back(T_BYTE | {24'h0, exp_b});
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            r[i] = b;
        end
        obs_bus.push_back(T_BYTE | {24'h0, r});
        wbit(~mack);
    endtask

    task automatic load_sample(input logic [11:0] v);
        int n;
        n = 0;
        @(negedge clk);
        sample_data  = v;
        sample_valid = 1'b1;
        while (!sample_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sample_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
        chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
        chk({tag, "_cfg_reg"}, 32'(cfg_reg), 32'h10);
        chk({tag, "_cfg_wr"}, 32'(cfg_wr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int oe0;
        rst          = 1'b1;
        scl_m        = 1'b1;
        sda_m        = 1'b1;
        sample_data  = 12'h000;
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_outs("in_reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_outs("after_reset");

        // 1: config write
        start_c();
        send_byte(8'h50, 1'b1);
        chk("t1_busy_after_addr", 32'(busy), 32'd1);
        exp_cfg.push_back(32'h30);
        send_byte(8'h30, 1'b1);
        stop_c();
        repeat (5) @(negedge clk);
        chk("t1_busy_after_stop", 32'(busy), 32'd0);
        chk("t1_cfg_reg", 32'(cfg_reg), 32'h30);

        // 2: two-byte read ending in NACK
        load_sample(12'hABC);
        start_c();
        send_byte(8'h51, 1'b1);
        recv_byte(8'h0A, 1'b1);
        recv_byte(8'hBC, 1'b0);
        chk("t2_released_before_stop", 32'(sda_oe), 32'd0);
        stop_c();
        repeat (5) @(negedge clk);
        chk("t2_busy_after_stop", 32'(busy), 32'd0);

        // 3: continuous read, new sample lands during the high byte
        load_sample(12'h123);
        start_c();
        send_byte(8'h51, 1'b1);
        fork
            recv_byte(8'h01, 1'b1);
            begin
                repeat (3 * Q) @(negedge clk);
                load_sample(12'h456);
            end
        join
        recv_byte(8'h23, 1'b1);
        recv_byte(8'h04, 1'b1);
        recv_byte(8'h56, 1'b0);
        stop_c();

        // 4: foreign address is never acknowledged
        oe0 = oe_cnt;
        start_c();
        send_byte(8'h53, 1'b0);
        chk("t4_busy", 32'(busy), 32'd0);
        stop_c();
        repeat (5) @(negedge clk);
        chk("t4_no_sda_drive", 32'(oe_cnt - oe0), 32'd0);
        chk("t4_cfg_unchanged", 32'(cfg_reg), 32'h30);

        // 5: repeated START inside the low byte, then a write
        load_sample(12'h785);
        start_c();
        send_byte(8'h51, 1'b1);
        recv_byte(8'h07, 1'b1);
        start_c();
        chk("t5_released_after_rstart", 32'(sda_oe), 32'd0);
        send_byte(8'h50, 1'b1);
        exp_cfg.push_back(32'h10);
        send_byte(8'h10, 1'b1);
        stop_c();
        repeat (5) @(negedge clk);
        chk("t5_cfg_reg", 32'(cfg_reg), 32'h10);

        // 6: reset while acknowledging the address
        start_c();
        for (int i = 7; i >= 0; i--) wbit(1'(8'h50 >> i));
        sda_m = 1'b1;
        qw();
        chk("t6_ack_driven", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_oe_on_rst", 32'(sda_oe), 32'd0);
        @(negedge clk);
        chk_reset_outs("t6_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_oe_after_rst", 32'(sda_oe), 32'd0);
        stop_c();
        start_c();
        send_byte(8'h51, 1'b1);
        recv_byte(8'h00, 1'b1);
        recv_byte(8'h00, 1'b0);
        stop_c();
        start_c();
        send_byte(8'h50, 1'b1);
        exp_cfg.push_back(32'h55);
        send_byte(8'h55, 1'b1);
        stop_c();
        repeat (10) @(negedge clk);
        chk("t6_cfg_reg", 32'(cfg_reg), 32'h55);

        chk("bus_exp_left", 32'(exp_bus.size()), 32'd0);
        chk("bus_obs_left", 32'(obs_bus.size()), 32'd0);
        chk("cfg_exp_left", 32'(exp_cfg.size()), 32'd0);
        chk("cfg_obs_left", 32'(obs_cfg.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
